// File: rtl/jtkcpu_intctl.sv
// KONAMI-1 interrupt front-end.
// Synchronises the active-low interrupt pins, edge-detects and arms NMI,
// masks FIRQ/IRQ with the CC flags, and turns the sequencer's intvec
// acknowledge into an int_ack pulse plus the vector fetch address.
module jtkcpu_intctl #(
    parameter logic [15:0] VEC_BASE = 16'hFFF0,
    parameter int          SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        nnmi,
    input  logic        nfirq,
    input  logic        nirq,
    input  logic        cc_f,
    input  logic        cc_i,
    input  logic        nmi_arm,
    input  logic        sync_wait,
    input  logic [3:0]  intvec,
    output logic        nmi,
    output logic        firq,
    output logic        irq,
    output logic        wake,
    output logic        int_ack,
    output logic [15:0] vec_addr
);

    localparam logic [15:0] VEC_NMI  = VEC_BASE + 16'h000C;
    localparam logic [15:0] VEC_FIRQ = VEC_BASE + 16'h0006;
    localparam logic [15:0] VEC_IRQ  = VEC_BASE + 16'h0008;
    localparam logic [15:0] VEC_RST  = VEC_BASE + 16'h000E;

    logic [SYNC_STG-1:0] nnmi_sh;
    logic [SYNC_STG-1:0] nfirq_sh;
    logic [SYNC_STG-1:0] nirq_sh;

    logic        nnmi_s;
    logic        nfirq_s;
    logic        nirq_s;
    logic        nfirq_pre;
    logic        nirq_pre;

    logic        nnmi_prev;
    logic        nmi_armed;
    logic [3:0]  intvec_prev;

    logic        nmi_edge;
    logic        nmi_served;
    logic        ack_start;
    logic [15:0] vec_next;

    assign nnmi_s  = nnmi_sh[SYNC_STG-1];
    assign nfirq_s = nfirq_sh[SYNC_STG-1];
    assign nirq_s  = nirq_sh[SYNC_STG-1];

    // The FIRQ/IRQ request register is itself the last synchroniser stage,
    // so it is fed from the stage before the end of the chain.
    assign nfirq_pre = nfirq_sh[SYNC_STG-2];
    assign nirq_pre  = nirq_sh[SYNC_STG-2];

    assign nmi_edge   = nmi_armed & nnmi_prev & ~nnmi_s;
    assign nmi_served = intvec[2] & ~intvec_prev[2];
    assign ack_start  = (intvec_prev == 4'd0) && (intvec != 4'd0);

    // Vector selection from the acknowledge code, NMI over FIRQ over IRQ.
    always_comb begin
        vec_next = VEC_RST;
        if (intvec[2]) begin
            vec_next = VEC_NMI;
        end else if (intvec[1]) begin
            vec_next = VEC_FIRQ;
        end else if (intvec[0]) begin
            vec_next = VEC_IRQ;
        end
    end

    // Pin synchronisers; reset to all ones so the pins read as deasserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            nnmi_sh  <= '1;
            nfirq_sh <= '1;
            nirq_sh  <= '1;
        end else if (cen) begin
            nnmi_sh  <= {nnmi_sh[SYNC_STG-2:0],  nnmi};
            nfirq_sh <= {nfirq_sh[SYNC_STG-2:0], nfirq};
            nirq_sh  <= {nirq_sh[SYNC_STG-2:0],  nirq};
        end
    end

    // NMI arming and edge latch; a new edge beats a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            nnmi_prev <= 1'b1;
            nmi_armed <= 1'b0;
            nmi       <= 1'b0;
        end else if (cen) begin
            nnmi_prev <= nnmi_s;
            if (nmi_arm) begin
                nmi_armed <= 1'b1;
            end
            if (nmi_edge) begin
                nmi <= 1'b1;
            end else if (nmi_served) begin
                nmi <= 1'b0;
            end
        end
    end

    // Level-sensitive masked FIRQ/IRQ requests and SYNC/CWAI wake-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            firq <= 1'b0;
            irq  <= 1'b0;
            wake <= 1'b0;
        end else if (cen) begin
            firq <= ~nfirq_pre & ~cc_f;
            irq  <= ~nirq_pre & ~cc_i;
            wake <= sync_wait & (~nnmi_s | ~nfirq_s | ~nirq_s);
        end
    end

    // Acknowledge pulse and vector address tracking the intvec code.
    always_ff @(posedge clk) begin
        if (rst) begin
            intvec_prev <= 4'd0;
            int_ack     <= 1'b0;
            vec_addr    <= VEC_RST;
        end else if (cen) begin
            intvec_prev <= intvec;
            int_ack     <= ack_start;
            vec_addr    <= vec_next;
        end
    end

endmodule

// File: doc/jtkcpu_intctl.md
Name: jtkcpu_intctl

Overview:
- Interrupt front-end for the KONAMI-1 core: the producer side of the irq/nmi/firq request lines that the microcode sequencer samples at each new-instruction point.
- Synchronises the active-low interrupt pins, edge-detects and arms NMI, and masks FIRQ/IRQ with the CC F/I flags.
- Consumes the sequencer's 4-bit intvec acknowledge, clears the serviced NMI latch, and supplies the vector fetch address.
- Sits between the core's external pins and the ucode/memory-address logic.

Parameters:
VEC_BASE  16'hFFF0  base of the vector table; offsets +0xC NMI, +0x6 FIRQ, +0x8 IRQ, +0xE reset
SYNC_STG  2         number of synchroniser flops per pin (minimum 2)

Ports:
clk       in   1   system clock
rst       in   1   synchronous reset, active high
cen       in   1   clock enable; all state advances only when cen=1
nnmi      in   1   NMI pin, active low, edge triggered
nfirq     in   1   FIRQ pin, active low, level
nirq      in   1   IRQ pin, active low, level
cc_f      in   1   CC F flag (1 masks FIRQ)
cc_i      in   1   CC I flag (1 masks IRQ)
nmi_arm   in   1   pulse from the register file when S is first written; arms NMI
sync_wait in   1   high while the core executes SYNC/CWAI
intvec    in   4   acknowledge from the sequencer: bit2 NMI, bit1 FIRQ, bit0 IRQ, 0 = none
nmi       out  1   NMI request to the sequencer
firq      out  1   masked FIRQ request
irq       out  1   masked IRQ request
wake      out  1   releases SYNC: any synchronised pin is asserted, regardless of mask
int_ack   out  1   one-cen-cycle pulse when intvec goes from zero to nonzero
vec_addr  out  16  vector address for the PC load

Behaviour:
- Reset values:
  - nmi=0, firq=0, irq=0, wake=0, int_ack=0, vec_addr=VEC_BASE+0xE.
  - nmi_armed=0; all synchronisers loaded with 1 (pins deasserted).
- Synchronisers: each pin shifts through SYNC_STG flops on cen. Request latency from a pin change to the output is SYNC_STG+1 cen cycles for NMI and SYNC_STG cen cycles for FIRQ/IRQ.
- NMI arming:
  - nmi_armed is set by nmi_arm and cleared only by rst.
  - While unarmed, NMI edges are discarded, not stored.
- NMI edge detection:
  - A registered copy of the synchronised nnmi is kept.
  - A 1→0 transition while armed sets nmi_lat.
  - nmi = nmi_lat.
- NMI acknowledge:
  - nmi_lat clears on the cen cycle where intvec[2]=1 and the registered previous intvec[2]=0.
  - If a new edge arrives in that same cycle, set wins and nmi stays 1.
  - A held-low nnmi does not retrigger; it must go high then low again.
- FIRQ/IRQ: registered each cen, with no latching (level semantics); deassertion of the pin drops the request.
  - firq = ~nfirq_s & ~cc_f.
  - irq = ~nirq_s & ~cc_i.
- wake = sync_wait & (~nnmi_s | ~nfirq_s | ~nirq_s), registered. Forced to 0 when sync_wait=0.
- int_ack and vec_addr:
  - int_ack pulses when the previous intvec was 0 and the current one is nonzero.
  - vec_addr is latched on the same cycle by priority: NMI > FIRQ > IRQ (VEC_BASE+0xC / +0x6 / +0x8).
  - vec_addr holds while intvec stays nonzero.
  - When intvec returns to 0, vec_addr returns to VEC_BASE+0xE the next cen cycle.
  - A change between two nonzero intvec codes re-latches vec_addr without a new int_ack.
- cen=0: every register holds; pin transitions are sampled only on cen cycles.
- rst mid-operation: pending NMI is lost and arming is lost; outputs return to reset values the next clk edge, independent of cen.

Test Plan:
- Reset with nmi_arm never pulsed; drive nnmi 1→0 → nmi stays 0 indefinitely.
- Pulse nmi_arm, then nnmi 1→0 and hold low → nmi=1 SYNC_STG+1 cycles later. Then intvec=4'b0100 → int_ack pulse, vec_addr=16'hFFFC, nmi=0 next cycle. Holding nnmi low does not re-raise nmi.
- nfirq=0, cc_f=1 → firq=0; clear cc_f → firq=1 after 1 cycle; release nfirq → firq=0 after SYNC_STG cycles.
- nirq=0 and nfirq=0 with masks clear, then intvec=4'b0011 → vec_addr=16'hFFF6 (FIRQ priority); intvec=0 → vec_addr=16'hFFFE.
- sync_wait=1, cc_i=1, nirq=0 → irq=0, wake=1. sync_wait=0 → wake=0.
- NMI edge coinciding with an intvec[2] rising-edge ack → nmi remains 1. Assert rst mid-stream → all outputs at reset values, nmi_armed=0.
